// File: rtl/ht_cmd_arbiter.sv
// ht_cmd_arbiter: round-robin merge of per-channel ht commands into one engine stream,
// with same-bucket hazard blocking and slot-tagged result routing back to the issuing channel.
module ht_cmd_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int KEY_WIDTH    = 32,
    parameter int VALUE_WIDTH  = 9,
    parameter int BUCKET_WIDTH = 8,
    parameter int MAX_INFLIGHT = 8,
    parameter int RES_WIDTH    = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_CH*KEY_WIDTH-1:0]     cmd_key_i,
    input  logic [NUM_CH*VALUE_WIDTH-1:0]   cmd_value_i,
    input  logic [NUM_CH*2-1:0]             cmd_opcode_i,
    input  logic [NUM_CH-1:0]               cmd_valid_i,
    output logic [NUM_CH-1:0]               cmd_ready_o,
    output logic [KEY_WIDTH-1:0]            eng_key_o,
    output logic [VALUE_WIDTH-1:0]          eng_value_o,
    output logic [1:0]                      eng_opcode_o,
    output logic [BUCKET_WIDTH-1:0]         eng_bucket_o,
    output logic [$clog2(MAX_INFLIGHT)-1:0] eng_slot_o,
    output logic                            eng_valid_o,
    input  logic                            eng_ready_i,
    input  logic [$clog2(MAX_INFLIGHT)-1:0] res_slot_i,
    input  logic [RES_WIDTH-1:0]            res_rescode_i,
    input  logic [VALUE_WIDTH-1:0]          res_value_i,
    input  logic                            res_valid_i,
    output logic                            res_ready_o,
    output logic [RES_WIDTH-1:0]            ch_res_rescode_o,
    output logic [VALUE_WIDTH-1:0]          ch_res_value_o,
    output logic [NUM_CH-1:0]               ch_res_valid_o,
    input  logic [NUM_CH-1:0]               ch_res_ready_i,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight_cnt_o,
    output logic                            err_stray_o
);
    localparam int SW = $clog2(MAX_INFLIGHT);
    localparam int CW = $clog2(NUM_CH);

    logic [MAX_INFLIGHT-1:0] slot_valid;
    logic [BUCKET_WIDTH-1:0] slot_bucket [MAX_INFLIGHT];
    logic [CW-1:0]           slot_ch [MAX_INFLIGHT];
    logic [KEY_WIDTH-1:0]    key [NUM_CH];
    logic [VALUE_WIDTH-1:0]  value [NUM_CH];
    logic [1:0]              opcode [NUM_CH];
    logic [NUM_CH-1:0]       elig;
    logic [CW-1:0]           rr, idx, gnt_ch, res_ch;
    logic [SW-1:0]           free_slot;
    logic                    can_issue, gnt, hit, retire;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign key[c]    = cmd_key_i[c*KEY_WIDTH +: KEY_WIDTH];
        assign value[c]  = cmd_value_i[c*VALUE_WIDTH +: VALUE_WIDTH];
        assign opcode[c] = cmd_opcode_i[c*2 +: 2];
    end

    // Hazards are checked against registered slot state only, so a freed bucket unblocks one cycle late.
    assign can_issue = !rst_i && !(&slot_valid) && (!eng_valid_o || eng_ready_i);

    always_comb begin
        elig = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = cmd_valid_i[c] && can_issue;
            for (int s = 0; s < MAX_INFLIGHT; s++)
                if (slot_valid[s] && slot_bucket[s] == key[c][BUCKET_WIDTH-1:0]) elig[c] = 1'b0;
        end
    end

    always_comb begin
        gnt = 1'b0;
        gnt_ch = '0;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CW'((int'(rr) + i) % NUM_CH);
            if (!gnt && elig[idx]) begin
                gnt = 1'b1;
                gnt_ch = idx;
            end
        end
    end

    always_comb begin
        free_slot = '0;
        for (int s = MAX_INFLIGHT - 1; s >= 0; s--)
            if (!slot_valid[s]) free_slot = SW'(s);
    end

    assign cmd_ready_o = gnt ? NUM_CH'(1) << gnt_ch : '0;

    // Results for empty slots are swallowed (ready high, no channel valid) and flagged.
    assign res_ch           = slot_ch[res_slot_i];
    assign hit              = slot_valid[res_slot_i];
    assign res_ready_o      = hit ? ch_res_ready_i[res_ch] : 1'b1;
    assign ch_res_valid_o   = (res_valid_i && hit) ? NUM_CH'(1) << res_ch : '0;
    assign retire           = res_valid_i && hit && ch_res_ready_i[res_ch];
    assign ch_res_rescode_o = res_rescode_i;
    assign ch_res_value_o   = res_value_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid <= '0;
            rr <= '0;
            eng_key_o <= '0;
            eng_value_o <= '0;
            eng_opcode_o <= '0;
            eng_bucket_o <= '0;
            eng_slot_o <= '0;
            eng_valid_o <= 1'b0;
            inflight_cnt_o <= '0;
            err_stray_o <= 1'b0;
        end else begin
            if (retire) slot_valid[res_slot_i] <= 1'b0;
            if (gnt) begin
                slot_valid[free_slot] <= 1'b1;
                slot_bucket[free_slot] <= key[gnt_ch][BUCKET_WIDTH-1:0];
                slot_ch[free_slot] <= gnt_ch;
                rr <= (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + 1'b1;
                eng_key_o <= key[gnt_ch];
                eng_value_o <= value[gnt_ch];
                eng_opcode_o <= opcode[gnt_ch];
                eng_bucket_o <= key[gnt_ch][BUCKET_WIDTH-1:0];
                eng_slot_o <= free_slot;
            end
            eng_valid_o <= gnt || (eng_valid_o && !eng_ready_i);
            inflight_cnt_o <= inflight_cnt_o + (SW+1)'(gnt) - (SW+1)'(retire);
            err_stray_o <= res_valid_i && !hit;
        end
    end
endmodule

// File: doc/ht_cmd_arbiter.md
Name: ht_cmd_arbiter

Overview:
- Multi-channel front end for the hash-table lookup/insert/delete engine.
- Accepts ht commands (key, value, opcode) from NUM_CH independent clients and merges them by round-robin into one command stream toward the engine.
- Blocks any command whose bucket matches a command still in flight, so same-bucket operations complete in order.
- Tags each issued command with an in-flight slot index and routes the engine's result back to the originating channel.

Parameters:
NUM_CH, 4, number of client channels (2..16)
KEY_WIDTH, 32, key width
VALUE_WIDTH, 9, value width (lock_status + owner_cnt)
BUCKET_WIDTH, 8, bucket index width; bucket = key[BUCKET_WIDTH-1:0] (dummy hash)
MAX_INFLIGHT, 8, in-flight slot count, power of 2
RES_WIDTH, 3, result code width (SEARCH_FOUND=0 .. DELETE_NOT_SUCCESS_NO_ENTRY=6)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cmd_key_i  in  NUM_CH*KEY_WIDTH  per-channel key, channel c at [c*KEY_WIDTH +: KEY_WIDTH]
cmd_value_i  in  NUM_CH*VALUE_WIDTH  per-channel value
cmd_opcode_i  in  NUM_CH*2  per-channel opcode (0 SEARCH, 1 INSERT, 2 DELETE, 3 INSERT2)
cmd_valid_i  in  NUM_CH  per-channel command valid
cmd_ready_o  out  NUM_CH  per-channel accept (one-hot or zero)
eng_key_o  out  KEY_WIDTH  issued key
eng_value_o  out  VALUE_WIDTH  issued value
eng_opcode_o  out  2  issued opcode
eng_bucket_o  out  BUCKET_WIDTH  issued bucket
eng_slot_o  out  $clog2(MAX_INFLIGHT)  issued tag
eng_valid_o  out  1  issued command valid
eng_ready_i  in  1  engine accepts command
res_slot_i  in  $clog2(MAX_INFLIGHT)  result tag
res_rescode_i  in  RES_WIDTH  result code
res_value_i  in  VALUE_WIDTH  found value
res_valid_i  in  1  result valid
res_ready_o  out  1  result accepted
ch_res_rescode_o  out  RES_WIDTH  result code, broadcast to all channels
ch_res_value_o  out  VALUE_WIDTH  found value, broadcast
ch_res_valid_o  out  NUM_CH  one-hot result valid
ch_res_ready_i  in  NUM_CH  per-channel result ready
inflight_cnt_o  out  $clog2(MAX_INFLIGHT)+1  occupied slots
err_stray_o  out  1  1-cycle pulse: result for an empty slot

Behaviour:
- Slot table: MAX_INFLIGHT registered entries {valid, bucket, ch_id}.
- Channel c is eligible when all of these hold:
  - cmd_valid_i[c] is high.
  - Its bucket matches no valid slot (compared against registered table state).
  - A free slot exists.
  - The output register can load: !eng_valid_o || eng_ready_i.
- Arbitration:
  - Round-robin pointer rr. Grant the first eligible channel at or after rr, wrapping around.
  - On a grant, rr <= granted+1 (mod NUM_CH). rr is unchanged when nothing is granted.
  - At most one grant per cycle. cmd_ready_o[g]=1 combinationally for the granted channel only.
- Issue:
  - On grant, allocate the lowest free slot.
  - Output register loads {key, value, opcode, bucket, slot}; eng_valid_o=1 the next cycle (1-cycle latency).
  - Output holds stable while eng_valid_o && !eng_ready_i.
  - The slot is marked valid at grant, not at engine handshake.
- Same-cycle same-bucket requests: only one is granted. The other is blocked from the next cycle by the table.
- Result routing (combinational):
  - ch = slot[res_slot_i].ch_id.
  - ch_res_valid_o[ch] = res_valid_i.
  - res_ready_o = ch_res_ready_i[ch].
  - On res_valid_i && res_ready_o, clear the slot at the clock edge.
- Freed slot / bucket visibility: a freed slot/bucket is not visible to eligibility until the following cycle. This is conservative; no bypass.
- Stray result (res_valid_i with slot not valid):
  - res_ready_o=1, ch_res_valid_o=0, result dropped.
  - err_stray_o pulses for 1 cycle.
- Allocate and free in the same cycle: both applied. inflight_cnt_o is unchanged.
- Full (inflight_cnt_o==MAX_INFLIGHT): no grants. Results still drain.
- Reset values:
  - All slots invalid, rr=0, eng_valid_o=0, inflight_cnt_o=0, err_stray_o=0, cmd_ready_o=0.
  - eng_* data fields 0.
  - Reset mid-operation drops any pending issue and all in-flight tracking.

Test Plan:
- Ch0 SEARCH key 0x0000_0105, engine ready -> cmd_ready_o=0001 same cycle; next cycle eng_valid_o=1, eng_bucket_o=0x05, eng_slot_o=0; result rescode 0 on slot 0 -> ch_res_valid_o=0001, inflight 1→0.
- All 4 channels valid, distinct buckets, rr=0, engine always ready -> grants 0,1,2,3 on 4 consecutive cycles, then 0 again if still valid.
- Ch0 INSERT key 0x12, ch1 DELETE key 0x212 (bucket 0x12) same cycle -> ch0 granted; ch1 blocked until 1 cycle after slot freed, then granted.
- eng_ready_i=0 for 5 cycles with eng_valid_o=1 -> eng_* stable, no new grants; ready=1 -> next grant the same cycle.
- 8 distinct-bucket commands, no results -> inflight_cnt_o=8, cmd_ready_o=0; one result -> next cycle one grant.
- res_valid_i on empty slot 3 -> res_ready_o=1, ch_res_valid_o=0, err_stray_o=1 for one cycle; rst_i mid-traffic -> all outputs to reset values next cycle.
